// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg
// Shared types and GF(2^w) helper functions for the Reed-Solomon syndrome
// calculator.
//   state_t       : syndrome engine state (ACCUM collects symbols, HOLD
//                   presents the result).
//   gf_mul        : generic carry-less multiply reduced modulo poly.
//   gf_alpha_pow  : alpha^k with alpha = 'h02, for elaboration-time roots.
// -----------------------------------------------------------------------------
package rs_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Shift-and-add multiply in GF(2^w); poly includes the x^w term, so a
    // carry into bit w is cancelled by XOR-ing the whole polynomial.
    function automatic logic [31:0] gf_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] poly,
                                           input int          w);
        logic [31:0] p;
        logic [31:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                if (b[i]) p = p ^ x;
                x = x << 1;
                if (x[w]) x = x ^ poly;
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] gf_alpha_pow(input int          k,
                                                 input logic [31:0] poly,
                                                 input int          w);
        logic [31:0] acc;
        acc = 32'd1;
        for (int i = 0; i < k; i++) begin
            acc = gf_mul(acc, 32'd2, poly, w);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_cmult.sv
// -----------------------------------------------------------------------------
// gf_cmult
// Constant-coefficient multiplier in GF(2^SYM_W): y = a * COEF mod POLY.
// Because COEF is a parameter, the loop collapses to a fixed XOR network.
//   a  in   SYM_W  multiplicand
//   y  out  SYM_W  product
// -----------------------------------------------------------------------------
module gf_cmult #(
    parameter int          SYM_W = 8,
    parameter logic [31:0] POLY  = 32'h11D,
    parameter logic [31:0] COEF  = 32'h002
) (
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);

    logic [SYM_W-1:0] x;
    logic [SYM_W-1:0] p;

    // NOTE: combinational blocks use blocking '=' and assign every variable
    // before any use, so no latch is inferred.
    always_comb begin
        x = a;
        p = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (COEF[i]) p = p ^ x;
            // Multiply running term by alpha, folding the overflow bit back.
            x = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? POLY[SYM_W-1:0] : '0);
        end
        y = p;
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// -----------------------------------------------------------------------------
// rs_syndrome_calc
// Streaming Reed-Solomon syndrome calculator (Horner evaluation of the
// received polynomial at alpha^(FCR+j), j = 0..N_SYN-1), highest degree first.
//   clk        in   1            clock
//   rst_n      in   1            asynchronous active-low reset
//   in_sym     in   SYM_W        received symbol
//   in_valid   in   1            in_sym valid
//   in_last    in   1            final symbol (degree 0)
//   in_erase   in   1            erasure flag (RS_ERASURE_CNT_EN only)
//   in_ready   out  1            accepting symbols (ACCUM)
//   syn_out    out  N_SYN*SYM_W  syndromes, S0 in LSBs
//   syn_valid  out  1            result valid (HOLD)
//   syn_ready  in   1            downstream accepts result
//   syn_nz     out  1            any syndrome non-zero
//   len_err    out  1            codeword length differed from N_SYM
//   era_cnt    out  clog2(N_SYM+1) erasure count
// Optional feature macro: RS_ERASURE_CNT_EN (erasure counter); when undefined
// era_cnt is tied to zero and in_erase is unused.
// -----------------------------------------------------------------------------
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int          SYM_W = 8,
    parameter logic [31:0] POLY  = 32'h11D,
    parameter int          N_SYM = 32,
    parameter int          N_SYN = 4,
    parameter int          FCR   = 0,
    localparam int         CNT_W = $clog2(N_SYM + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SYM_W-1:0]       in_sym,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   in_erase,
    output logic                   in_ready,
    output logic [N_SYN*SYM_W-1:0] syn_out,
    output logic                   syn_valid,
    input  logic                   syn_ready,
    output logic                   syn_nz,
    output logic                   len_err,
    output logic [CNT_W-1:0]       era_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SYM - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] syn_q    [N_SYN];
    logic [SYM_W-1:0] prod     [N_SYN];
    logic [SYM_W-1:0] syn_next [N_SYN];
    logic             nz_next;
    logic             accept;
    logic             end_beat;

    // in_ready is a decode of the registered state, never of syn_ready.
    assign accept   = in_valid && (state == ACCUM);
    assign end_beat = in_last || (cnt == LAST_IDX);

    for (genvar j = 0; j < N_SYN; j++) begin : g_syn
        localparam logic [31:0] ROOT = gf_alpha_pow(FCR + j, POLY, SYM_W);

        gf_cmult #(
            .SYM_W (SYM_W),
            .POLY  (POLY),
            .COEF  (ROOT)
        ) u_mult (
            .a (syn_q[j]),
            .y (prod[j])
        );

        assign syn_out[j*SYM_W +: SYM_W] = syn_q[j];
    end

    // Horner step; the first beat loads the symbol directly so no separate
    // clear cycle is needed between codewords.
    always_comb begin
        nz_next = 1'b0;
        for (int j = 0; j < N_SYN; j++) begin
            syn_next[j] = (cnt == '0) ? in_sym : (prod[j] ^ in_sym);
            nz_next     = nz_next | (|syn_next[j]);
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            in_ready  <= 1'b1;
            syn_valid <= 1'b0;
            syn_nz    <= 1'b0;
            len_err   <= 1'b0;
            for (int j = 0; j < N_SYN; j++) syn_q[j] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int j = 0; j < N_SYN; j++) syn_q[j] <= syn_next[j];
                        if (end_beat) begin
                            state     <= HOLD;
                            cnt       <= '0;
                            in_ready  <= 1'b0;
                            syn_valid <= 1'b1;
                            syn_nz    <= nz_next;
                            len_err   <= (cnt != LAST_IDX) || !in_last;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (syn_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        syn_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    syn_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RS_ERASURE_CNT_EN
    logic [CNT_W-1:0] era_q;

    // Counter restarts on the first beat and only moves on accepted beats,
    // so it is frozen throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            era_q <= '0;
        end else if (accept) begin
            era_q <= (cnt == '0) ? CNT_W'(in_erase) : era_q + CNT_W'(in_erase);
        end
    end

    assign era_cnt = era_q;
`else
    logic unused_erase;
    assign unused_erase = in_erase;
    assign era_cnt      = '0;
`endif

endmodule
